// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV row issuer front end.
package spmv_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int IDX_W_DEF  = 32;
    localparam int ROW_W_DEF  = 32;

    localparam logic [63:0] DBL_ZERO = 64'h0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BASE  = 3'd1,
        NEXT  = 3'd2,
        PAIRS = 3'd3,
        FIN   = 3'd4
    } state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready holding register; the owner decides when to load it.
module axis_reg_slice #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         free_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // A slot may be refilled in the same cycle its current beat drains.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Holding register: load wins over drain, data held while valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/spmv_row_issuer.sv
// CSR row-pointer to TIMES converter that forwards VAL/VEC as lockstep A/B pairs.
// Define SPMV_EMPTY_ROW_PAD_EN to turn empty rows into one 0.0 x 0.0 pad pair.
module spmv_row_issuer
    import spmv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic              err_ptr,
    input  logic [IDX_W-1:0]  S_AXIS_ROWPTR_tdata,
    input  logic              S_AXIS_ROWPTR_tvalid,
    output logic              S_AXIS_ROWPTR_tready,
    input  logic [DATA_W-1:0] S_AXIS_VAL_tdata,
    input  logic              S_AXIS_VAL_tvalid,
    output logic              S_AXIS_VAL_tready,
    input  logic [DATA_W-1:0] S_AXIS_VEC_tdata,
    input  logic              S_AXIS_VEC_tvalid,
    output logic              S_AXIS_VEC_tready,
    output logic [DATA_W-1:0] M_AXIS_A_tdata,
    output logic              M_AXIS_A_tvalid,
    input  logic              M_AXIS_A_tready,
    output logic [DATA_W-1:0] M_AXIS_B_tdata,
    output logic              M_AXIS_B_tvalid,
    input  logic              M_AXIS_B_tready,
    output logic [IDX_W-1:0]  M_AXIS_TIMES_tdata,
    output logic              M_AXIS_TIMES_tvalid,
    input  logic              M_AXIS_TIMES_tready
);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   rows_left_q, rows_left_d;
    logic [IDX_W-1:0]   prev_q, prev_d;
    logic [IDX_W-1:0]   pairs_left_q, pairs_left_d;
    logic               pad_q, pad_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_free_s, b_free_s, times_free_s;
    logic               times_load_s, pair_load_s;
    logic [IDX_W-1:0]   times_din_s, len_s, row_cnt_s;
    logic               ptr_bad_s, src_ok_s;
    logic               rowptr_ready_s, src_ready_s;
    logic [DATA_W-1:0]  a_din_s, b_din_s;

    // A non-monotonic pointer yields an empty row rather than a huge wrapped count.
    assign ptr_bad_s = S_AXIS_ROWPTR_tdata < prev_q;
    assign len_s     = ptr_bad_s ? '0 : (S_AXIS_ROWPTR_tdata - prev_q);
`ifdef SPMV_EMPTY_ROW_PAD_EN
    assign row_cnt_s = (len_s == '0) ? IDX_W'(1) : len_s;
`else
    assign row_cnt_s = len_s;
`endif
    assign src_ok_s  = pad_q || (S_AXIS_VAL_tvalid && S_AXIS_VEC_tvalid);
    assign a_din_s   = pad_q ? DATA_W'(DBL_ZERO) : S_AXIS_VAL_tdata;
    assign b_din_s   = pad_q ? DATA_W'(DBL_ZERO) : S_AXIS_VEC_tdata;

    // Next-state and handshake decode for the row/pair sequencer.
    always_comb begin
        state_d        = state_q;
        rows_left_d    = rows_left_q;
        prev_d         = prev_q;
        pairs_left_d   = pairs_left_q;
        pad_d          = pad_q;
        err_d          = err_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        rowptr_ready_s = 1'b0;
        src_ready_s    = 1'b0;
        times_load_s   = 1'b0;
        times_din_s    = '0;
        pair_load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_left_d = num_rows;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (num_rows == '0) ? FIN : BASE;
                end else begin
                    state_d = IDLE;
                end
            end
            BASE: begin
                rowptr_ready_s = 1'b1;
                if (S_AXIS_ROWPTR_tvalid) begin
                    prev_d  = S_AXIS_ROWPTR_tdata;
                    state_d = NEXT;
                end else begin
                    state_d = BASE;
                end
            end
            NEXT: begin
                rowptr_ready_s = times_free_s;
                if (times_free_s && S_AXIS_ROWPTR_tvalid) begin
                    prev_d       = S_AXIS_ROWPTR_tdata;
                    err_d        = err_q || ptr_bad_s;
                    times_load_s = 1'b1;
                    times_din_s  = row_cnt_s;
                    pairs_left_d = row_cnt_s;
                    pad_d        = (len_s == '0);
                    rows_left_d  = rows_left_q - ROW_W'(1);
                    if (row_cnt_s != '0) begin
                        state_d = PAIRS;
                    end else begin
                        state_d = (rows_left_q == ROW_W'(1)) ? FIN : NEXT;
                    end
                end else begin
                    state_d = NEXT;
                end
            end
            PAIRS: begin
                // VAL and VEC only ever move together; pad pairs move neither.
                if (a_free_s && b_free_s && src_ok_s) begin
                    pair_load_s  = 1'b1;
                    src_ready_s  = !pad_q;
                    pad_d        = 1'b0;
                    pairs_left_d = pairs_left_q - IDX_W'(1);
                    if (pairs_left_q == IDX_W'(1)) begin
                        state_d = (rows_left_q == '0) ? FIN : NEXT;
                    end else begin
                        state_d = PAIRS;
                    end
                end else begin
                    state_d = PAIRS;
                end
            end
            FIN: begin
                if (!M_AXIS_A_tvalid && !M_AXIS_B_tvalid && !M_AXIS_TIMES_tvalid) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rows_left_q  <= '0;
            prev_q       <= '0;
            pairs_left_q <= '0;
            pad_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_left_q  <= rows_left_d;
            prev_q       <= prev_d;
            pairs_left_q <= pairs_left_d;
            pad_q        <= pad_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err_ptr              = err_q;
    assign S_AXIS_ROWPTR_tready = rowptr_ready_s;
    assign S_AXIS_VAL_tready    = src_ready_s;
    assign S_AXIS_VEC_tready    = src_ready_s;

    axis_reg_slice #(.W(DATA_W)) u_a_slice (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pair_load_s),
        .data_i  (a_din_s),
        .ready_i (M_AXIS_A_tready),
        .valid_o (M_AXIS_A_tvalid),
        .data_o  (M_AXIS_A_tdata),
        .free_o  (a_free_s)
    );

    axis_reg_slice #(.W(DATA_W)) u_b_slice (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pair_load_s),
        .data_i  (b_din_s),
        .ready_i (M_AXIS_B_tready),
        .valid_o (M_AXIS_B_tvalid),
        .data_o  (M_AXIS_B_tdata),
        .free_o  (b_free_s)
    );

    axis_reg_slice #(.W(IDX_W)) u_times_slice (
        .clk     (clk),
        .rst     (rst),
        .load_i  (times_load_s),
        .data_i  (times_din_s),
        .ready_i (M_AXIS_TIMES_tready),
        .valid_o (M_AXIS_TIMES_tvalid),
        .data_o  (M_AXIS_TIMES_tdata),
        .free_o  (times_free_s)
    );

endmodule

// File: tb/tb_spmv_row_issuer.sv
// Directed bench for spmv_row_issuer; expectations follow SPMV_EMPTY_ROW_PAD_EN when defined.
module tb_spmv_row_issuer;

    typedef logic [63:0] q64_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num_rows = 32'd0;
    logic        busy, done, err_ptr;
    logic [31:0] rp_data = 32'd0;
    logic        rp_valid = 1'b0, rp_ready;
    logic [63:0] val_data = 64'd0, vec_data = 64'd0;
    logic        val_valid = 1'b0, val_ready, vec_valid = 1'b0, vec_ready;
    logic [63:0] a_data, b_data;
    logic        a_valid, b_valid, t_valid;
    logic        a_ready = 1'b1, b_ready = 1'b1, t_ready = 1'b1;
    logic [31:0] t_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int run_start = 0;
    int mode = 0;
    int val_n = 0, vec_n = 0, done_cnt = 0, done_edge = 0, last_out_edge = 0;
    q64_t rp_q, val_q, vec_q, a_got, b_got, t_got, a_exp, b_exp, t_exp;
    logic rp_f, val_f, vec_f;

    always #5 clk = ~clk;

    spmv_row_issuer dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_rows             (num_rows),
        .busy                 (busy),
        .done                 (done),
        .err_ptr              (err_ptr),
        .S_AXIS_ROWPTR_tdata  (rp_data),
        .S_AXIS_ROWPTR_tvalid (rp_valid),
        .S_AXIS_ROWPTR_tready (rp_ready),
        .S_AXIS_VAL_tdata     (val_data),
        .S_AXIS_VAL_tvalid    (val_valid),
        .S_AXIS_VAL_tready    (val_ready),
        .S_AXIS_VEC_tdata     (vec_data),
        .S_AXIS_VEC_tvalid    (vec_valid),
        .S_AXIS_VEC_tready    (vec_ready),
        .M_AXIS_A_tdata       (a_data),
        .M_AXIS_A_tvalid      (a_valid),
        .M_AXIS_A_tready      (a_ready),
        .M_AXIS_B_tdata       (b_data),
        .M_AXIS_B_tvalid      (b_valid),
        .M_AXIS_B_tready      (b_ready),
        .M_AXIS_TIMES_tdata   (t_data),
        .M_AXIS_TIMES_tvalid  (t_valid),
        .M_AXIS_TIMES_tready  (t_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input q64_t got, input q64_t exp);
        check_val({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check_val($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    function automatic logic [63:0] vval(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] xval(input int i);
        return 64'h3C3C_0000_0000_1000 + 64'(i);
    endfunction

    // Source drivers and output monitors: sample mid-cycle, update after the edge.
    initial begin
        forever begin
            @(negedge clk);
            rp_f  = rp_valid && rp_ready;
            val_f = val_valid && val_ready;
            vec_f = vec_valid && vec_ready;
            if (val_f) val_n++;
            if (vec_f) vec_n++;
            if (a_valid && a_ready) begin a_got.push_back(a_data); last_out_edge = cyc + 1; end
            if (b_valid && b_ready) begin b_got.push_back(b_data); last_out_edge = cyc + 1; end
            if (t_valid && t_ready) begin t_got.push_back({32'd0, t_data}); last_out_edge = cyc + 1; end
            if (done) begin done_cnt++; done_edge = cyc; end
            @(posedge clk);
            cyc++;
            #1;
            if (rp_f && rp_q.size() > 0) void'(rp_q.pop_front());
            if (val_f && val_q.size() > 0) void'(val_q.pop_front());
            if (vec_f && vec_q.size() > 0) void'(vec_q.pop_front());
            rp_valid  = rp_q.size() > 0;
            rp_data   = rp_valid ? rp_q[0][31:0] : 32'd0;
            val_valid = val_q.size() > 0;
            val_data  = val_valid ? val_q[0] : 64'd0;
            vec_valid = vec_q.size() > 0;
            vec_data  = vec_valid ? vec_q[0] : 64'd0;
            case (mode)
                1: begin
                    a_ready = ((cyc - run_start) % 2) == 0;
                    b_ready = !((cyc - run_start) >= 4 && (cyc - run_start) < 8);
                    t_ready = 1'b1;
                end
                2: begin a_ready = 1'b0; b_ready = 1'b0; t_ready = 1'b1; end
                default: begin a_ready = 1'b1; b_ready = 1'b1; t_ready = 1'b1; end
            endcase
        end
    end

    task automatic prep(input int nvals);
        @(posedge clk);
        #2;
        val_q = {}; vec_q = {}; a_got = {}; b_got = {}; t_got = {};
        a_exp = {}; b_exp = {}; t_exp = {};
        val_n = 0; vec_n = 0;
        for (int i = 0; i < nvals; i++) begin
            val_q.push_back(vval(i));
            vec_q.push_back(xval(i));
        end
    endtask

    task automatic run(input string tag, input int nrows, input int budget, output int waited);
        logic got;
        @(posedge clk);
        #1;
        num_rows  = nrows;
        start     = 1'b1;
        run_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        waited = 1;
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        got = done;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            got = done;
        end
        check_val({tag, "_done"}, 64'(got), 64'd1);
        check_val({tag, "_busy_clr"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int w;
        int dc0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err_ptr), 64'd0);
        check_val("rst_valids", {61'd0, a_valid, b_valid, t_valid}, 64'd0);
        check_val("rst_readies", {61'd0, rp_ready, val_ready, vec_ready}, 64'd0);
        check_val("rst_tdata", a_data | b_data | {32'd0, t_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two rows of 3 and 2 elements, downstream always ready.
        mode = 0;
        prep(5);
        rp_q = {64'd0, 64'd3, 64'd5};
        t_exp = {64'd3, 64'd2};
        for (int i = 0; i < 5; i++) begin a_exp.push_back(vval(i)); b_exp.push_back(xval(i)); end
        run("t1", 2, 200, w);
        check_stream("t1_times", t_got, t_exp);
        check_stream("t1_a", a_got, a_exp);
        check_stream("t1_b", b_got, b_exp);
        check_val("t1_err", 64'(err_ptr), 64'd0);
        check_val("t1_done_lat", 64'(done_edge - last_out_edge), 64'd1);
        check_val("t1_rp_left", 64'(rp_q.size()), 64'd0);

        // Same matrix with A toggling and B stalled for a while.
        mode = 1;
        prep(5);
        rp_q = {64'd0, 64'd3, 64'd5};
        t_exp = {64'd3, 64'd2};
        for (int i = 0; i < 5; i++) begin a_exp.push_back(vval(i)); b_exp.push_back(xval(i)); end
        run("t2", 2, 200, w);
        check_stream("t2_times", t_got, t_exp);
        check_stream("t2_a", a_got, a_exp);
        check_stream("t2_b", b_got, b_exp);
        check_val("t2_val_n", 64'(val_n), 64'd5);
        check_val("t2_vec_n", 64'(vec_n), 64'd5);

        // Empty first and last rows.
        mode = 0;
        prep(2);
        rp_q = {64'd4, 64'd4, 64'd6, 64'd6};
`ifdef SPMV_EMPTY_ROW_PAD_EN
        t_exp = {64'd1, 64'd2, 64'd1};
        a_exp = {64'd0, vval(0), vval(1), 64'd0};
        b_exp = {64'd0, xval(0), xval(1), 64'd0};
`else
        t_exp = {64'd0, 64'd2, 64'd0};
        a_exp = {vval(0), vval(1)};
        b_exp = {xval(0), xval(1)};
`endif
        run("t3", 3, 200, w);
        check_stream("t3_times", t_got, t_exp);
        check_stream("t3_a", a_got, a_exp);
        check_stream("t3_b", b_got, b_exp);
        check_val("t3_err", 64'(err_ptr), 64'd0);

        // Decreasing row pointer flags an error and yields an empty row.
        prep(5);
        rp_q = {64'd0, 64'd5, 64'd3};
        for (int i = 0; i < 5; i++) begin a_exp.push_back(vval(i)); b_exp.push_back(xval(i)); end
`ifdef SPMV_EMPTY_ROW_PAD_EN
        t_exp = {64'd5, 64'd1};
        a_exp.push_back(64'd0);
        b_exp.push_back(64'd0);
`else
        t_exp = {64'd5, 64'd0};
`endif
        run("t4", 2, 200, w);
        check_stream("t4_times", t_got, t_exp);
        check_stream("t4_a", a_got, a_exp);
        check_stream("t4_b", b_got, b_exp);
        check_val("t4_err", 64'(err_ptr), 64'd1);
        repeat (5) @(negedge clk);
        check_val("t4_err_sticky", 64'(err_ptr), 64'd1);

        // Zero rows: no pointer consumed, done within two cycles, error cleared.
        prep(0);
        rp_q = {64'd77};
        run("t6", 0, 10, w);
        check_val("t6_latency_ok", 64'(w <= 2), 64'd1);
        check_val("t6_err_clr", 64'(err_ptr), 64'd0);
        check_val("t6_rp_untouched", 64'(rp_q.size()), 64'd1);
        check_val("t6_times_none", 64'(t_got.size()), 64'd0);

        // Reset while stuck in PAIRS with two pairs still owed.
        mode = 2;
        prep(3);
        rp_q = {64'd0, 64'd3};
        @(posedge clk);
        #1;
        num_rows = 32'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t5_busy_pre", 64'(busy), 64'd1);
        check_val("t5_a_valid_pre", 64'(a_valid), 64'd1);
        check_val("t5_val_n_pre", 64'(val_n), 64'd1);
        #2;
        rst = 1'b1;
        dc0 = done_cnt;
        val_q = {};
        vec_q = {};
        rp_q  = {};
        #1;
        check_val("t5_valids_rst", {61'd0, a_valid, b_valid, t_valid}, 64'd0);
        check_val("t5_busy_rst", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mode = 0;
        repeat (5) @(negedge clk);
        check_val("t5_no_done", 64'(done_cnt - dc0), 64'd0);
        prep(1);
        rp_q = {64'd0, 64'd1};
        t_exp = {64'd1};
        a_exp = {vval(0)};
        b_exp = {xval(0)};
        run("t5b", 1, 200, w);
        check_stream("t5b_times", t_got, t_exp);
        check_stream("t5b_a", a_got, a_exp);
        check_stream("t5b_b", b_got, b_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spmv_row_issuer.md
Name: spmv_row_issuer

Overview:
- Front end of the SpMV dot-product datapath; drives the A/B/TIMES input streams of the per-row dot-product kernel.
- Converts a CSR row-pointer stream into per-row element counts (TIMES).
- Forwards matrix values (A) and gathered vector values (B) as count-matched lockstep pairs.
- Runs one matrix per start pulse and reports completion and malformed row pointers.

Parameters:
- DATA_W, 64, width of A/B operands (IEEE double)
- IDX_W, 32, width of row-pointer entries and TIMES
- ROW_W, 32, width of the row counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; ignored unless busy=0
- num_rows  in  ROW_W  rows to issue; sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last pair and last TIMES accepted
- err_ptr  out  1  sticky non-monotonic row-pointer flag; cleared by start
- S_AXIS_ROWPTR_tdata/tvalid/tready  in/in/out  IDX_W/1/1  CSR row-pointer entries, num_rows+1 per matrix
- S_AXIS_VAL_tdata/tvalid/tready  in/in/out  DATA_W/1/1  matrix nonzero values
- S_AXIS_VEC_tdata/tvalid/tready  in/in/out  DATA_W/1/1  gathered x values, aligned to VAL
- M_AXIS_A_tdata/tvalid/tready  out/out/in  DATA_W/1/1  to kernel A
- M_AXIS_B_tdata/tvalid/tready  out/out/in  DATA_W/1/1  to kernel B
- M_AXIS_TIMES_tdata/tvalid/tready  out/out/in  IDX_W/1/1  per-row element count

Behaviour:
- Reset values:
  - All tvalid, busy, done and err_ptr = 0.
  - All tready = 0; all tdata = 0.
  - FSM = IDLE.
- FSM states:
  - IDLE: on start, latch rows_left=num_rows and clear err_ptr, then go to BASE. If num_rows=0, go straight to FIN instead.
  - BASE: accept one ROWPTR and store it as prev, then go to NEXT.
  - NEXT: accept ROWPTR p only when the TIMES register is free (tvalid=0, or tready=1 this cycle).
    - len = p - prev (IDX_W wrap arithmetic); prev <= p.
    - If p < prev (unsigned): set err_ptr and force len = 0.
    - Load TIMES, set pairs_left = len, decrement rows_left.
    - Go to PAIRS if len>0; otherwise to NEXT, or to FIN if rows_left reaches 0.
  - PAIRS: forward pairs until pairs_left = 0, then go to NEXT, or to FIN if rows_left = 0.
  - FIN: wait until A, B and TIMES tvalid are all 0; pulse done; clear busy; return to IDLE.
- Output registers:
  - One-entry register on each of A, B and TIMES.
  - tvalid stays high until tready; tdata is stable while tvalid is high.
- Pair transfer (PAIRS state only):
  - A slot free = A_tvalid==0 or A_tready==1; same rule for the B slot.
  - A pair is transferred in the cycle where both slots are free and VAL_tvalid && VEC_tvalid.
  - That cycle: VAL_tready = VEC_tready = 1, both registers load, pairs_left decrements.
  - VAL/VEC are never consumed singly; A and B may drain independently.
- TIMES is loaded before that row's first pair, so row N's TIMES is never issued after any row N pair.
- Throughput: one pair per clock when downstream is always ready; latency from VAL/VEC to A/B is 1 clock.
- ROWPTR_tready is high only in BASE, and in NEXT when the TIMES slot is free.
- start while busy is ignored.
- Asynchronous rst mid-operation:
  - Drops all valids immediately and returns the FSM to IDLE.
  - Partially issued rows are discarded; no done pulse.
- len and pairs_left are IDX_W wide; rows_left is ROW_W wide.

Optional Feature:
- Macro: SPMV_EMPTY_ROW_PAD_EN.
- Defined: a row with len=0 (including a forced 0 after err_ptr) emits TIMES=1 and one pad pair A=0.0, B=0.0, so the kernel outputs +0.0 for that row. The pad pair consumes no VAL/VEC beats.
- Undefined: an empty row emits TIMES=0 and no pairs.

Decomposition:
- Shared package spmv_pkg holds:
  - FSM state enum (IDLE, BASE, NEXT, PAIRS, FIN);
  - DATA_W/IDX_W defaults;
  - constant DBL_ZERO = 64'h0.
- One natural sub-module: axis_reg_slice, a one-entry valid/ready holding register.
  - Instantiate it three times (A, B, TIMES).
  - Its load-enable is driven by the FSM.

Test Plan:
- num_rows=2, ROWPTR 0,3,5, VAL/VEC 5 beats, all readies high:
  - TIMES = 3, 2; A/B carry the 5 pairs in order; done 1 cycle after last accept; err_ptr = 0.
- Same stimulus, A_tready toggles 1/0 while B_tready is held 0 for 4 cycles:
  - no VAL/VEC beat is lost or duplicated;
  - A and B sequences are each identical to their inputs;
  - VAL and VEC beat counts stay equal.
- num_rows=3, ROWPTR 4,4,6,6:
  - Macro undefined: TIMES = 0, 2, 0 and 2 pairs.
  - Macro defined: TIMES = 1, 2, 1 and 4 pairs, with the pad pairs = 0.0.
- num_rows=2, ROWPTR 0,5,3:
  - TIMES = 5, 0 (1 with macro); err_ptr = 1 until the next start; done still pulses.
- rst asserted in PAIRS state with 2 pairs pending:
  - all tvalid = 0 immediately; busy = 0; no done;
  - a new start with ROWPTR 0,1 and num_rows=1 gives TIMES=1 and 1 pair.
- num_rows=0 start: no ROWPTR consumed; done pulses within 2 cycles.
